alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter and sequencer for the single shared RV32I ALU. The execute stage (port 0) and the branch-compare unit (port 1) each present operand/opcode requests over valid/ready. The block grants one request per cycle using round-robin and drives the shared `alu` instance. It registers the ALU result and flags, then returns them to the granted port through a single-entry response register with backpressure.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes port 0 always win.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid && ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands.
- `req0_sel` / `req1_sel`  in  4  ALU opcode: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- `rsp0_valid` / `rsp1_valid`  out  1  result held for that port.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer takes the result.
- `rsp_out`  out  32  registered ALU result, shared by both ports and qualified by `rspN_valid`.
- `rsp_zero`, `rsp_lt_s`, `rsp_lt_u`  out  1  registered ALU flags.
- `rsp_illegal`  out  1  the captured sel was 1010–1111.
- `busy_cnt`  out  16  saturating count of cycles in state FULL.

## Operation
- FSM states are EMPTY and FULL; there is one response slot.
- **EMPTY:** if any `reqN_valid` is high, grant one request. On the rising edge, capture the ALU outputs, the illegal flag and the owner port, then go to FULL.
- **FULL:** `rsp<owner>_valid` is 1. When `rsp<owner>_ready` is 1:
  - if a new request is granted in the same cycle, reload the slot and stay FULL (back-to-back);
  - otherwise go to EMPTY.
- **Ready rule:** `reqN_ready` = granted_N && (state==EMPTY || rsp<owner>_ready). The granted port is decided from the current valids and the priority pointer. `reqN_ready` never asserts for a port that is not granted.
- **Round-robin arbitration:**
  - the pointer `last_grant` updates only on an accepted request;
  - when both ports are valid, grant the port other than `last_grant`;
  - when only one port is valid, grant that port.
- **Illegal opcode (sel ≥ 1010):** accepted normally; `rsp_out` = 0, all flags 0, `rsp_illegal` = 1.
- The ALU is purely combinational. The block muxes the granted port's A/B/sel into it.
- A non-granted `reqN_valid` must be held by the requester. The arbiter does not record it.
- `busy_cnt` increments each cycle in FULL and saturates at 0xFFFF.

## Timing
- **Latency:** a request accepted in cycle N has its response visible in cycle N+1.
- **Throughput:** 1 request/cycle when the owner's `rsp_ready` is held high.
- **Reset values:**
  - state EMPTY;
  - `rspN_valid` 0;
  - `rsp_out` 0;
  - all flags 0;
  - `rsp_illegal` 0;
  - `last_grant` 1, so port 0 wins the first tie;
  - `busy_cnt` 0;
  - `reqN_ready` evaluates to the EMPTY-state rule.
- **Reset mid-operation:** the pending response is discarded immediately (asynchronous). No response is produced for it.
- **Backpressure:** while FULL and the owner's `rsp_ready` is 0:
  - `rsp_out` and flags hold stable;
  - both `reqN_ready` are 0.
- **Wrong-port ready:** `rspN_ready` on the non-owner port is ignored.
- **Combinational paths:** `rspN_ready` → `reqN_ready` is permitted. There is no path from response ready to `rsp_out`.

## Structure
- **Shared package `alu_pkg`:**
  - opcode localparams `ALU_ADD`…`ALU_SLTU`;
  - `ALU_SEL_W` = 4;
  - `XLEN` = 32;
  - FSM state encoding EMPTY/FULL;
  - `is_legal_sel` function.
- **Sub-module:** the existing `alu` is instantiated once, ports A, B, sel, alu_out, zero, lt_signed, lt_unsigned.
- The grant logic stays inline; no separate arbiter module.

## Test plan
- **Single ADD:** port 0 sends A=10, B=20, sel=0000 with `rsp0_ready`=1. Required: `rsp0_valid` in the next cycle, `rsp_out`=30, zero=0, `rsp1_valid`=0.
- **Tie round-robin:** both ports valid for 4 cycles, with port 0 SUB 20-10 and port 1 SLT A=-5, B=10, both rsp_ready=1. Required grants alternate 0,1,0,1. Port 0 results are 10 with flags 0. Port 1 results are `rsp_out`=1, `rsp_lt_s`=1, `rsp_lt_u`=0.
- **Backpressure:** port 1 sends SLTU A=0xFFFFFFFF, B=1, then `rsp1_ready` is held 0 for 3 cycles. Required during those cycles: `rsp_out`=0 and `lt_u`=0 held stable, both `reqN_ready`=0, `busy_cnt`=3. When ready rises, the FSM returns to EMPTY.
- **Back-to-back:** port 0 streams SLL 1<<8, SRL 0x80000000>>4, SRA 0x80000000>>4. Required: results 0x100, 0x08000000, 0xF8000000 on consecutive cycles.
- **Illegal sel:** port 0 sends sel=1100. Required: `rsp_illegal`=1, `rsp_out`=0, all flags 0. The next legal request gets `rsp_illegal`=0.
- **Mid-op reset:** assert `rst` while FULL. Required in the same cycle: `rspN_valid`=0 and `busy_cnt`=0. After release, a tie grants port 0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU and the two-port ALU arbiter.
package alu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b1001;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_t;

    function automatic logic is_legal_sel(input logic [ALU_SEL_W-1:0] sel);
        return sel <= ALU_SLTU;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; undefined opcodes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]      A,
    input  logic [XLEN-1:0]      B,
    input  logic [ALU_SEL_W-1:0] sel,
    output logic [XLEN-1:0]      alu_out,
    output logic                 zero,
    output logic                 lt_signed,
    output logic                 lt_unsigned
);

    always_comb begin
        lt_signed   = $signed(A) < $signed(B);
        lt_unsigned = A < B;
        case (sel)
            ALU_ADD:  alu_out = A + B;
            ALU_SUB:  alu_out = A - B;
            ALU_XOR:  alu_out = A ^ B;
            ALU_OR:   alu_out = A | B;
            ALU_AND:  alu_out = A & B;
            ALU_SLL:  alu_out = A << B[4:0];
            ALU_SRL:  alu_out = A >> B[4:0];
            ALU_SRA:  alu_out = $unsigned($signed(A) >>> B[4:0]);
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:  alu_out = '0;
        endcase
        zero = (alu_out == '0);
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one ALU; single-entry registered response slot with backpressure.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [XLEN-1:0]      req0_a,
    input  logic [XLEN-1:0]      req0_b,
    input  logic [ALU_SEL_W-1:0] req0_sel,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [XLEN-1:0]      req1_a,
    input  logic [XLEN-1:0]      req1_b,
    input  logic [ALU_SEL_W-1:0] req1_sel,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [XLEN-1:0]      rsp_out,
    output logic                 rsp_zero,
    output logic                 rsp_lt_s,
    output logic                 rsp_lt_u,
    output logic                 rsp_illegal,
    output logic [15:0]          busy_cnt
);

    state_t              state_q, state_d;
    logic                owner_q;
    logic                last_grant_q;
    logic [XLEN-1:0]     rsp_out_q;
    logic                zero_q, lt_s_q, lt_u_q, illegal_q;
    logic [15:0]         busy_cnt_q;

    logic                any_valid, grant, owner_ready, accept;
    logic [XLEN-1:0]     alu_a, alu_b, alu_res;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                alu_zero, alu_lt_s, alu_lt_u, legal;

    always_comb begin
        any_valid = req0_valid | req1_valid;
        // On a tie the port that did not win last time goes next.
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        owner_ready = owner_q ? rsp1_ready : rsp0_ready;
        accept      = any_valid && ((state_q == StEmpty) || owner_ready);
        req0_ready  = accept && !grant;
        req1_ready  = accept && grant;
        alu_a       = grant ? req1_a : req0_a;
        alu_b       = grant ? req1_b : req0_b;
        alu_sel     = grant ? req1_sel : req0_sel;
        legal       = is_legal_sel(alu_sel);
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if ((state_q == StFull) && owner_ready) begin
            state_d = StEmpty;
        end
    end

    alu u_alu (
        .A           (alu_a),
        .B           (alu_b),
        .sel         (alu_sel),
        .alu_out     (alu_res),
        .zero        (alu_zero),
        .lt_signed   (alu_lt_s),
        .lt_unsigned (alu_lt_u)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_out_q    <= '0;
            zero_q       <= 1'b0;
            lt_s_q       <= 1'b0;
            lt_u_q       <= 1'b0;
            illegal_q    <= 1'b0;
            busy_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                rsp_out_q    <= legal ? alu_res : '0;
                zero_q       <= legal & alu_zero;
                lt_s_q       <= legal & alu_lt_s;
                lt_u_q       <= legal & alu_lt_u;
                illegal_q    <= ~legal;
            end
            if ((state_q == StFull) && (busy_cnt_q != 16'hFFFF)) begin
                busy_cnt_q <= busy_cnt_q + 16'd1;
            end
        end
    end

    assign rsp0_valid  = (state_q == StFull) && !owner_q;
    assign rsp1_valid  = (state_q == StFull) && owner_q;
    assign rsp_out     = rsp_out_q;
    assign rsp_zero    = zero_q;
    assign rsp_lt_s    = lt_s_q;
    assign rsp_lt_u    = lt_u_q;
    assign rsp_illegal = illegal_q;
    assign busy_cnt    = busy_cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed scenarios followed by random traffic.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_sel = 0, req1_sel = 0;
    logic [31:0] rsp_out;
    logic        rsp_zero, rsp_lt_s, rsp_lt_u, rsp_illegal;
    logic [15:0] busy_cnt;

    always #5 clk = ~clk;

    alu_share_arb #(.FIXED_PRIO(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sel    (req0_sel),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sel    (req1_sel),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_out     (rsp_out),
        .rsp_zero    (rsp_zero),
        .rsp_lt_s    (rsp_lt_s),
        .rsp_lt_u    (rsp_lt_u),
        .rsp_illegal (rsp_illegal),
        .busy_cnt    (busy_cnt)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] out;
        logic        z, ls, lu, ill;
    } rsp_t;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;
    // Reference view: is a response pending, whose is it, who won last, FULL-cycle count.
    bit   pend  = 0;
    bit   pport = 0;
    bit   last  = 1;
    int   busy  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t ref_rsp(input logic port, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] s);
        rsp_t r;
        r.port = port;
        r.ill  = (s > 4'd9);
        case (s)
            4'd0:    r.out = a + b;
            4'd1:    r.out = a - b;
            4'd2:    r.out = a ^ b;
            4'd3:    r.out = a | b;
            4'd4:    r.out = a & b;
            4'd5:    r.out = a << b[4:0];
            4'd6:    r.out = a >> b[4:0];
            4'd7:    r.out = $signed(a) >>> b[4:0];
            4'd8:    r.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    r.out = (a < b) ? 32'd1 : 32'd0;
            default: r.out = 32'd0;
        endcase
        r.z  = !r.ill && (r.out == 0);
        r.ls = !r.ill && ($signed(a) < $signed(b));
        r.lu = !r.ill && (a < b);
        return r;
    endfunction

    // One clock cycle of stimulus; expects to start just after a rising edge.
    task automatic cyc(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] s0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [3:0] s1, input logic r0,
                       input logic r1);
        logic g, cons, acc;
        rsp_t item;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
        rsp0_ready = r0; rsp1_ready = r1;
        item = '0;
        @(negedge clk);
        g    = (v0 && v1) ? ~last : v1;
        cons = pend && (pport ? r1 : r0);
        acc  = (v0 || v1) && (!pend || cons);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, acc && !g});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, acc && g});
        chk("busy_cnt", {16'b0, busy_cnt}, busy);
        if (pend && busy < 65535) busy++;
        if (acc) begin
            item  = g ? ref_rsp(1'b1, a1, b1, s1) : ref_rsp(1'b0, a0, b0, s0);
            pport = g;
            last  = g;
            pend  = 1;
        end else if (cons) begin
            pend = 0;
        end
        @(posedge clk);
        if (acc) q.push_back(item);
        #1;
    endtask

    task automatic idle(input logic r0, input logic r1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic p0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                      input logic r0);
        cyc(1, a, b, s, 0, 0, 0, 0, r0, 1);
    endtask

    // Asynchronous reset applied mid-cycle; the pending slot must vanish at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_busy_cnt", {16'b0, busy_cnt}, 32'd0);
        q.delete();
        pend = 0;
        last = 1;
        busy = 0;
        req0_valid = 0;
        req1_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (q.size() > 0 || rsp0_valid || rsp1_valid)) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
            end else begin
                chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, !q[0].port});
                chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, q[0].port});
                chk("rsp_out", rsp_out, q[0].out);
                chk("rsp_flags", {28'b0, rsp_zero, rsp_lt_s, rsp_lt_u, rsp_illegal},
                    {28'b0, q[0].z, q[0].ls, q[0].lu, q[0].ill});
                if (q[0].port ? rsp1_ready : rsp0_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("reset_rsp_out", rsp_out, 32'd0);
        chk("reset_flags", {28'b0, rsp_zero, rsp_lt_s, rsp_lt_u, rsp_illegal}, 32'd0);
        chk("reset_busy_cnt", {16'b0, busy_cnt}, 32'd0);
        rst = 1'b0;

        // Single ADD
        p0(32'd10, 32'd20, 4'd0, 1);
        idle(1, 1);

        // Tie: SUB on port 0, SLT on port 1, grants must alternate
        repeat (4) cyc(1, 32'd20, 32'd10, 4'd1, 1, 32'hFFFF_FFFB, 32'd10, 4'd8, 1, 1);
        idle(1, 1);

        // Backpressure on port 1 with port 0 ready wiggling (wrong port)
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 4'd9, 1, 0);
        repeat (3) cyc(1, 32'd1, 32'd1, 4'd0, 1, 32'd3, 32'd4, 4'd0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1, 1);

        // Back-to-back shifts
        p0(32'd1, 32'd8, 4'd5, 1);
        p0(32'h8000_0000, 32'd4, 4'd6, 1);
        p0(32'h8000_0000, 32'd4, 4'd7, 1);
        idle(1, 1);

        // Illegal opcode then a legal one
        p0(32'd5, 32'd5, 4'd12, 1);
        p0(32'd0, 32'd0, 4'd0, 1);
        idle(1, 1);

        // Reset while FULL, then a tie must go to port 0
        p0(32'd7, 32'd7, 4'd0, 0);
        do_reset();
        cyc(1, 32'd3, 32'd4, 4'd2, 1, 32'd5, 32'd6, 4'd3, 1, 1);
        idle(1, 1);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)),
                4'($urandom_range(0, 15)),
                $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)),
                4'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) idle(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
